// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 initiator: FSM encoding, clock
// polarity/phase and the transfer-length helper.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;

    // System clock cycles from cs falling to the done strobe.
    function automatic int xfer_cycles(input int data_w, input int clk_div);
        return (2 * data_w + 2) * clk_div;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Host-side handshake of spi_master: the host drives start/tx_data, the
// block returns rx_data, busy and done.
interface spi_master_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              busy;
    logic              done;

    modport master (output start, tx_data, input rx_data, busy, done);
    modport slave  (input start, tx_data, output rx_data, busy, done);
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period divider for spi_master: a tick every CLK_DIV enabled cycles,
// plus sclk and one-cycle strobes flagging the edge sclk makes at that tick.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sclk
);

    localparam int              CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             sclk_reg;

    assign tick = en && (cnt_reg == CNT_MAX);
    assign rise = tick && toggle_en && (sclk_reg == SPI_CPOL);
    assign fall = tick && toggle_en && (sclk_reg != SPI_CPOL);
    assign sclk = sclk_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            sclk_reg <= SPI_CPOL;
        end else if (!en) begin
            cnt_reg  <= '0;
            sclk_reg <= SPI_CPOL;
        end else begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
            if (rise) begin
                sclk_reg <= ~SPI_CPOL;
            end else if (fall) begin
                sclk_reg <= SPI_CPOL;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: shifts one DATA_W word out on mosi while capturing miso.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order (default MSB-first).
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.slave  host,
    output logic         cs,
    output logic         sclk,
    output logic         mosi,
    input  logic         miso
);

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB_FIRST = 1'b1;
`else
    localparam bit LSB_FIRST = 1'b0;
`endif

    localparam int               EDGE_W    = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    // CPHA=0: capture on the leading sclk edge, launch on the trailing one.
    localparam bit CAPTURE_ON_LEAD = (SPI_CPHA == 1'b0);

    spi_state_t        state_reg;
    logic              cs_reg;
    logic              mosi_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic [DATA_W-1:0] tx_shift_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic [EDGE_W-1:0] edge_cnt_reg;

    logic              tick, rise, fall;
    logic              capture, launch;
    logic [DATA_W-1:0] tx_shift_next;
    logic [DATA_W-1:0] rx_shift_next;
    logic              tx_head;
    logic              tx_next_bit;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (state_reg != ST_IDLE),
        .toggle_en (state_reg == ST_XFER),
        .tick      (tick),
        .rise      (rise),
        .fall      (fall),
        .sclk      (sclk)
    );

    assign capture = CAPTURE_ON_LEAD ? rise : fall;
    assign launch  = CAPTURE_ON_LEAD ? fall : rise;

    always_comb begin
        if (LSB_FIRST) begin
            tx_head       = host.tx_data[0];
            tx_next_bit   = tx_shift_reg[1];
            tx_shift_next = tx_shift_reg >> 1;
            rx_shift_next = {miso, rx_shift_reg[DATA_W-1:1]};
        end else begin
            tx_head       = host.tx_data[DATA_W-1];
            tx_next_bit   = tx_shift_reg[DATA_W-2];
            tx_shift_next = tx_shift_reg << 1;
            rx_shift_next = {rx_shift_reg[DATA_W-2:0], miso};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cs_reg       <= 1'b1;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rx_data_reg  <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            edge_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // busy still reads 1 in the done cycle, which blocks a start there.
                    busy_reg <= 1'b0;
                    if (host.start && !busy_reg) begin
                        state_reg    <= ST_SETUP;
                        cs_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                        tx_shift_reg <= host.tx_data;
                        mosi_reg     <= tx_head;
                        rx_shift_reg <= '0;
                        edge_cnt_reg <= '0;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        state_reg <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (tick) begin
                        edge_cnt_reg <= edge_cnt_reg + 1'b1;
                        if (capture) begin
                            rx_shift_reg <= rx_shift_next;
                        end
                        // The final trailing edge leaves mosi on the last bit.
                        if (launch && (edge_cnt_reg != LAST_EDGE)) begin
                            tx_shift_reg <= tx_shift_next;
                            mosi_reg     <= tx_next_bit;
                        end
                        if (edge_cnt_reg == LAST_EDGE) begin
                            state_reg <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        state_reg   <= ST_IDLE;
                        cs_reg      <= 1'b1;
                        done_reg    <= 1'b1;
                        rx_data_reg <= rx_shift_reg;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign cs           = cs_reg;
    assign mosi         = mosi_reg;
    assign host.busy    = busy_reg;
    assign host.done    = done_reg;
    assign host.rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: table vectors, random transfers against a
// bit-order model, and hand-written corner sequences (CLK_DIV=4 and CLK_DIV=1).
`timescale 1ns/1ps
module tb_spi_master;
    import spi_pkg::*;

    localparam int W    = 8;
    localparam int LAT0 = (2 * W + 2) * 4;
    localparam int LAT1 = (2 * W + 2) * 1;

`ifdef SPI_MASTER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(W)) h0 ();
    spi_master_if #(.DATA_W(W)) h1 ();

    logic cs0, sclk0, mosi0, miso0, miso_drv, loop0;
    logic cs1, sclk1, mosi1;

    assign miso0 = loop0 ? mosi0 : miso_drv;

    spi_master #(.DATA_W(W), .CLK_DIV(4)) dut (
        .clk(clk), .rst(rst), .host(h0), .cs(cs0), .sclk(sclk0), .mosi(mosi0), .miso(miso0)
    );
    spi_master #(.DATA_W(W), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .host(h1), .cs(cs1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit k of word w in transmission order.
    function automatic logic bit_at(input logic [W-1:0] w, input int k);
        return LSB ? w[k] : w[W-1-k];
    endfunction

    // Wire order of a word, first bit sent in the MSB of the result.
    function automatic logic [W-1:0] wire_order(input logic [W-1:0] w);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < W; k++) s = {s[W-2:0], bit_at(w, k)};
        return s;
    endfunction

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] mword;
        bit           loop;
        bit           inject;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_seq;
    } vec_t;

    // One transfer on dut; seq collects mosi as seen on each rising sclk.
    task automatic xfer0(input vec_t v, output logic [W-1:0] rx, output logic [W-1:0] seq,
                         output int rises, output int lat);
        logic prev_sclk;
        int   t;
        int   cs_low;
        bit   seen;
        loop0    = v.loop;
        miso_drv = bit_at(v.mword, 0);
        @(negedge clk);
        h0.start   = 1'b1;
        h0.tx_data = v.tx;
        @(negedge clk);
        h0.start   = 1'b0;
        h0.tx_data = W'($urandom);
        check("cs_fall", cs0, 1'b0);
        check("busy_set", h0.busy, 1'b1);
        t = 0; rises = 0; seq = '0; prev_sclk = sclk0; lat = -1; seen = 1'b0; rx = '0;
        for (int i = 0; i < 400; i++) begin
            if (v.inject && t == 3) begin
                h0.start   = 1'b1;
                h0.tx_data = 8'h55;
            end else begin
                h0.start = 1'b0;
            end
            if (sclk0 && !prev_sclk) begin
                if (!cs0) begin
                    seq = {seq[W-2:0], mosi0};
                    rises++;
                end
                if (rises < W) miso_drv = bit_at(v.mword, rises);
            end
            prev_sclk = sclk0;
            if (h0.done) begin
                seen = 1'b1;
                lat  = t;
                rx   = h0.rx_data;
                check("cs_high_at_done", cs0, 1'b1);
                check("busy_at_done", h0.busy, 1'b1);
                break;
            end
            @(negedge clk);
            t++;
        end
        h0.start = 1'b0;
        check("done_seen", seen, 1'b1);
        @(negedge clk);
        check("busy_drop", h0.busy, 1'b0);
        check("done_one_cycle", h0.done, 1'b0);
        cs_low = 0;
        repeat (12) begin
            @(negedge clk);
            if (!cs0) cs_low++;
        end
        check("no_second_xfer", cs_low, 0);
        $display("xfer tx=%h miso=%h loop=%0d inject=%0d rx=%h seq=%h rises=%0d lat=%0d",
                 v.tx, v.mword, v.loop, v.inject, rx, seq, rises, lat);
    endtask

    task automatic run_vec(input vec_t v);
        logic [W-1:0] rx, seq;
        int rises, lat;
        xfer0(v, rx, seq, rises, lat);
        check("rx_data", rx, v.exp_rx);
        check("mosi_seq", seq, v.exp_seq);
        check("rise_count", rises, W);
        check("done_latency", lat, LAT0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        vec_t rv;
        logic prev;
        int   rises, done_cnt, low, gap, t;
        bit   seen;

        rst = 1'b1; h0.start = 1'b0; h0.tx_data = '0; h1.start = 1'b0; h1.tx_data = '0;
        loop0 = 1'b1; miso_drv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs", cs0, 1'b1);
        check("rst_sclk", sclk0, 1'b0);
        check("rst_mosi", mosi0, 1'b0);
        check("rst_busy", h0.busy, 1'b0);
        check("rst_done", h0.done, 1'b0);
        check("rst_rx", h0.rx_data, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_cs", cs0, 1'b1);

        // 0xBD reads the same in either bit order.
        vecs[0] = '{tx: 8'hBD, mword: 8'h00, loop: 1'b1, inject: 1'b0, exp_rx: 8'hBD, exp_seq: 8'hBD};
        vecs[1] = '{tx: 8'h00, mword: 8'hFF, loop: 1'b0, inject: 1'b0, exp_rx: 8'hFF, exp_seq: 8'h00};
        vecs[2] = '{tx: 8'h5A, mword: 8'hC3, loop: 1'b0, inject: 1'b0, exp_rx: 8'hC3, exp_seq: wire_order(8'h5A)};
        vecs[3] = '{tx: 8'hBD, mword: 8'h00, loop: 1'b1, inject: 1'b1, exp_rx: 8'hBD, exp_seq: 8'hBD};
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        for (int i = 0; i < 6; i++) begin
            rv.tx      = W'($urandom);
            rv.mword   = W'($urandom);
            rv.loop    = 1'($urandom_range(0, 1));
            rv.inject  = 1'b0;
            rv.exp_rx  = rv.loop ? rv.tx : rv.mword;
            rv.exp_seq = wire_order(rv.tx);
            run_vec(rv);
        end

        // Reset after the 4th rising sclk edge.
        loop0 = 1'b1;
        @(negedge clk);
        h0.start = 1'b1; h0.tx_data = 8'hC6;
        @(negedge clk);
        h0.start = 1'b0;
        rises = 0; prev = sclk0;
        for (int i = 0; i < 200 && rises < 4; i++) begin
            @(negedge clk);
            if (sclk0 && !prev) rises++;
            prev = sclk0;
        end
        check("rst_reach_edge4", rises, 4);
        rst = 1'b1;
        #1;
        check("midrst_cs", cs0, 1'b1);
        check("midrst_sclk", sclk0, 1'b0);
        check("midrst_busy", h0.busy, 1'b0);
        check("midrst_done", h0.done, 1'b0);
        check("midrst_rx", h0.rx_data, 8'h00);
        done_cnt = 0; low = 0;
        repeat (3) begin
            @(negedge clk);
            if (h0.done) done_cnt++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (h0.done) done_cnt++;
            if (!cs0) low++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_stays_idle", low, 0);
        $display("xfer reset-mid tx=c6 rises=%0d rx=%h", rises, h0.rx_data);

        // CLK_DIV=1 back-to-back loopback words.
        @(negedge clk);
        h1.start = 1'b1; h1.tx_data = 8'hA5;
        @(negedge clk);
        h1.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (h1.done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("b2b_done1_seen", seen, 1'b1);
        check("b2b_rx1", h1.rx_data, 8'hA5);
        check("b2b_cs_at_done", cs1, 1'b1);
        $display("xfer clkdiv1 tx=a5 rx=%h", h1.rx_data);
        // Raise start in the done cycle (must be ignored) and keep it for the next cycle.
        h1.start = 1'b1; h1.tx_data = 8'h3C;
        gap = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) h1.start = 1'b0;
            if (!cs1) break;
            if (!h1.done) gap++;
        end
        h1.start = 1'b0;
        check("b2b_cs_gap", gap, 1);
        seen = 1'b0; t = 0;
        for (int i = 0; i < 100; i++) begin
            if (h1.done) begin seen = 1'b1; break; end
            @(negedge clk);
            t++;
        end
        check("b2b_done2_seen", seen, 1'b1);
        check("b2b_rx2", h1.rx_data, 8'h3C);
        check("b2b_latency", t, LAT1);
        check("b2b_pkg_len", xfer_cycles(W, 1), LAT1);
        $display("xfer clkdiv1 tx=3c rx=%h gap=%0d lat=%0d", h1.rx_data, gap, t);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI mode-0 controller (initiator) that drives cs, sclk and mosi and samples miso. It is the opposite end of our spi_device responder.
- A host loads one word and pulses start.
- The block shifts the word out MSB-first while capturing the device's reply.
- It then reports completion with a one-cycle done strobe.
- It sits between on-chip control logic and the external or on-chip spi_device.

Parameters:
DATA_W, 8, bits per transfer (≥2)
CLK_DIV, 4, system clk cycles per sclk half-period (≥1)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
start  input  1  transfer request; sampled only when busy=0
tx_data  input  DATA_W  word to transmit; captured on accepted start
rx_data  output  DATA_W  last received word; updated only with done
busy  output  1  high from the cycle after an accepted start until done inclusive
done  output  1  one-cycle pulse at end of transfer
cs  output  1  chip select, active-low (idle 1)
sclk  output  1  serial clock, idle 0 (CPOL=0, CPHA=0)
mosi  output  1  serial data out
miso  input  1  serial data in

Behaviour:
- Reset (async assert, sync release): cs=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0. State goes to IDLE and the divider counter is cleared.
- States:
  - IDLE: start=1 latches tx_data into the shift register and moves to SETUP. Next cycle: cs=0, busy=1, mosi=tx_data[DATA_W-1].
  - SETUP: hold for CLK_DIV cycles, then go to XFER.
  - XFER: sclk toggles every CLK_DIV cycles, starting with a rising edge.
    - Each rising edge: shift miso into the LSB of the rx shift register.
    - Each falling edge: drive mosi with the next tx bit.
    - After the falling edge that follows the DATA_W-th rising edge, go to HOLD. mosi holds the last bit, not a new one.
  - HOLD: hold for CLK_DIV cycles with sclk=0. In the final cycle: cs=1, done=1, rx_data=shift register. Return to IDLE.
- busy drops the cycle after done.
- Timing: cs falls 1 cycle after start is sampled. done rises exactly (2*DATA_W+2)*CLK_DIV cycles after cs falls, in the same cycle cs rises.
- mosi is stable for CLK_DIV cycles before each rising sclk edge.
- Back-to-back: start may be asserted in the done cycle and is ignored. The earliest accepted start is the cycle after done. cs stays high for at least 1 cycle between words.
- start while busy=1: ignored; tx_data changes while busy have no effect.
- Reset mid-transfer: immediate return to reset values. No done pulse; rx_data is cleared.
- CLK_DIV=1: sclk period is 2 system cycles; all rules above still hold.

Optional Feature:
SPI_MASTER_LSB_FIRST_EN
- Defined: bit order is LSB-first on both mosi and miso.
  - First mosi bit is tx_data[0].
  - The received first bit lands in rx_data[0].
- Undefined (default): MSB-first as above, matching spi_device.
- Timing is identical in both cases.

Decomposition:
- spi_pkg holds:
  - state encoding (IDLE, SETUP, XFER, HOLD)
  - CPOL/CPHA constants
  - a function computing transfer length in cycles, for the bench
- Sub-module spi_clk_gen: CLK_DIV counter emitting one-cycle rise/fall strobes and the sclk level, enabled only in SETUP/XFER/HOLD.

Test Plan:
- DATA_W=8, CLK_DIV=4, miso looped to mosi, send 8'd189 (0xBD):
  - mosi sequence on the 8 rising edges is 1,0,1,1,1,1,0,1
  - rx_data=0xBD at done
  - done occurs 72 cycles after cs falls
- miso tied 1, tx_data=0x00 -> mosi stays 0 for all bits; rx_data=0xFF; exactly 8 rising sclk edges while cs=0.
- Pulse start again 3 cycles into a transfer with tx_data=0x55 -> ignored; rx_data and done timing equal the single-transfer case; no second transfer.
- Assert rst mid-XFER (after the 4th rising edge) -> in the same cycle cs=1, sclk=0, busy=0; no done pulse; rx_data=0.
- CLK_DIV=1, two back-to-back starts (second start the cycle after done), loopback with 0xA5 then 0x3C:
  - rx_data equals 0xA5 then 0x3C
  - cs high for exactly 1 cycle between the two words
- With SPI_MASTER_LSB_FIRST_EN, loopback 0xBD -> mosi order is 1,0,1,1,1,1,0,1 reversed (1,0,1,1,1,1,0,1 read LSB-first); rx_data=0xBD.
